// File: rtl/laser_if.sv
// rtl/laser_if.sv - point stream and centre result bundle for the laser coverage optimizer
interface laser_if;
    logic [3:0] X;
    logic [3:0] Y;
    logic [3:0] C1X;
    logic [3:0] C1Y;
    logic [3:0] C2X;
    logic [3:0] C2Y;
    logic       DONE;

    modport master (output X, Y, input C1X, C1Y, C2X, C2Y, DONE);
    modport slave  (input X, Y, output C1X, C1Y, C2X, C2Y, DONE);
endinterface

// File: rtl/laser.sv
// rtl/laser.sv - two-circle (radius 4) coverage optimizer over 40 streamed grid points
module laser (
    input  logic    CLK,
    input  logic    RST,
    laser_if.slave  bus
);
    typedef enum logic [1:0] {READ, SEARCH, FINISH} state_t;

    state_t     state, state_n;
    logic [5:0] cnt;
    logic [3:0] px [40];
    logic [3:0] py [40];
    logic [3:0] c1x, c1y, c2x, c2y;
    logic [5:0] best;
    logic [7:0] cand;          // {cy, cx}: cx is the fast-moving coordinate
    logic [2:0] pass;          // 1..6; odd passes move C1, even passes move C2
    logic       init;          // first cycle of a pass: load best from the current centres
    logic       improved;
    logic       done;

    logic       move_c1, other_en, better, last_cand, finish_pass;
    logic [3:0] mx, my, ox, oy;
    logic [5:0] ucount;

    // Signed distance test; the diff range -15..15 squared and summed fits easily in 10 bits.
    function automatic logic covers(input logic [3:0] cx, input logic [3:0] cy,
                                    input logic [3:0] qx, input logic [3:0] qy);
        logic signed [9:0] dx, dy, d2;
        dx = signed'({6'b0, cx}) - signed'({6'b0, qx});
        dy = signed'({6'b0, cy}) - signed'({6'b0, qy});
        d2 = dx * dx + dy * dy;
        return d2 <= 10'sd16;
    endfunction

    assign move_c1   = pass[0];
    assign other_en  = (pass != 3'd1);
    assign mx        = init ? (move_c1 ? c1x : c2x) : cand[3:0];
    assign my        = init ? (move_c1 ? c1y : c2y) : cand[7:4];
    assign ox        = move_c1 ? c2x : c1x;
    assign oy        = move_c1 ? c2y : c1y;
    assign better    = (ucount > best);
    assign last_cand = (cand == 8'hff);
    assign finish_pass = (pass == 3'd6) || (other_en && !(improved || better));

    // Union coverage of the moving centre (candidate or current) with the fixed one, all points at once.
    always_comb begin
        ucount = '0;
        for (int i = 0; i < 40; i++) begin
            if (covers(mx, my, px[i], py[i]) || (other_en && covers(ox, oy, px[i], py[i])))
                ucount = ucount + 6'd1;
        end
    end

    // Point storage needs no reset; only indices already written during READ are ever used.
    always_ff @(posedge CLK) begin
        if (state == READ) begin
            px[cnt] <= bus.X;
            py[cnt] <= bus.Y;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= READ;
        else      state <= state_n;
    end

    // Next-state and DONE decode.
    always_comb begin
        state_n = state;
        done    = 1'b0;
        case (state)
            READ:    if (cnt == 6'd39) state_n = SEARCH;
            SEARCH:  if (!init && last_cand && finish_pass) state_n = FINISH;
            FINISH: begin
                done    = 1'b1;
                state_n = READ;
            end
            default: state_n = READ;
        endcase
    end

    // Capture counter, pass bookkeeping and centre updates.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt      <= '0;
            c1x      <= '0;
            c1y      <= '0;
            c2x      <= '0;
            c2y      <= '0;
            best     <= '0;
            cand     <= '0;
            pass     <= 3'd1;
            init     <= 1'b1;
            improved <= 1'b0;
        end else begin
            case (state)
                READ: begin
                    cnt      <= cnt + 6'd1;
                    cand     <= '0;
                    pass     <= 3'd1;
                    init     <= 1'b1;
                    improved <= 1'b0;
                end
                SEARCH: begin
                    if (init) begin
                        best     <= ucount;
                        init     <= 1'b0;
                        cand     <= '0;
                        improved <= 1'b0;
                    end else begin
                        if (better) begin
                            best     <= ucount;
                            improved <= 1'b1;
                            if (move_c1) begin
                                c1x <= cand[3:0];
                                c1y <= cand[7:4];
                            end else begin
                                c2x <= cand[3:0];
                                c2y <= cand[7:4];
                            end
                        end
                        cand <= cand + 8'd1;
                        if (last_cand && !finish_pass) begin
                            pass <= pass + 3'd1;
                            init <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    // Centres were presented this cycle; start the next set clean.
                    cnt  <= '0;
                    c1x  <= '0;
                    c1y  <= '0;
                    c2x  <= '0;
                    c2y  <= '0;
                    best <= '0;
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign bus.C1X  = c1x;
    assign bus.C1Y  = c1y;
    assign bus.C2X  = c2x;
    assign bus.C2Y  = c2y;
    assign bus.DONE = done;
endmodule

// File: tb/tb_laser.sv
// tb/tb_laser.sv - randomized self-checking bench for laser against a pass-level reference model
module tb_laser;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    laser_if bus ();
    laser dut (.CLK(clk), .RST(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int px [40];
    int py [40];
    int obs1x, obs1y, obs2x, obs2y;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit cov(input int cx, input int cy, input int qx, input int qy);
        return ((cx - qx) * (cx - qx) + (cy - qy) * (cy - qy)) <= 16;
    endfunction

    function automatic int union_cnt(input int ax, input int ay, input int bx, input int by, input bit ben);
        int n = 0;
        for (int i = 0; i < 40; i++)
            if (cov(ax, ay, px[i], py[i]) || (ben && cov(bx, by, px[i], py[i]))) n++;
        return n;
    endfunction

    // Alternating hill-climb straight from the rules: pass 1 moves C1 alone, then C2, C1, ...
    task automatic model(output int r1x, output int r1y, output int r2x, output int r2y, output int np);
        int c[2][2];
        c = '{'{0, 0}, '{0, 0}};
        np = 0;
        for (int p = 1; p <= 6; p++) begin
            int mv = (p % 2 == 1) ? 0 : 1;
            int ot = 1 - mv;
            bit ben = (p != 1);
            int best;
            bit imp = 0;
            np = p;
            best = union_cnt(c[mv][0], c[mv][1], c[ot][0], c[ot][1], ben);
            for (int cy = 0; cy < 16; cy++)
                for (int cx = 0; cx < 16; cx++) begin
                    int u = union_cnt(cx, cy, c[ot][0], c[ot][1], ben);
                    if (u > best) begin
                        best = u;
                        c[mv][0] = cx;
                        c[mv][1] = cy;
                        imp = 1;
                    end
                end
            if (p >= 2 && !imp) break;
        end
        r1x = c[0][0]; r1y = c[0][1]; r2x = c[1][0]; r2y = c[1][1];
    endtask

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : (v > 15) ? 15 : v;
    endfunction

    task automatic gen_random(input bit clustered);
        int ax = int'($urandom_range(15));
        int ay = int'($urandom_range(15));
        int bx = int'($urandom_range(15));
        int by = int'($urandom_range(15));
        for (int i = 0; i < 40; i++) begin
            if (!clustered) begin
                px[i] = int'($urandom_range(15));
                py[i] = int'($urandom_range(15));
            end else if ($urandom_range(1) == 0) begin
                px[i] = clamp(ax + int'($urandom_range(6)) - 3);
                py[i] = clamp(ay + int'($urandom_range(6)) - 3);
            end else begin
                px[i] = clamp(bx + int'($urandom_range(6)) - 3);
                py[i] = clamp(by + int'($urandom_range(6)) - 3);
            end
        end
    endtask

    task automatic feed_points(output bit done_seen);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            bus.X = 4'(px[i]);
            bus.Y = 4'(py[i]);
            @(posedge clk);
            @(negedge clk);
            if (bus.DONE) done_seen = 1;
        end
        bus.X = 4'($urandom_range(15));
        bus.Y = 4'($urandom_range(15));
    endtask

    // Entered at a negedge with point 0 due on the next edge; leaves at the negedge where point 0 of the next set may be driven.
    task automatic run_set(input string tag, input int max_lat);
        int e1x, e1y, e2x, e2y, np, lat;
        bit done_in_read;
        model(e1x, e1y, e2x, e2y, np);
        feed_points(done_in_read);
        check_eq({tag, " done_in_read"}, int'(done_in_read), 0);
        lat = 0;
        while (bus.DONE !== 1'b1 && lat < max_lat) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check_eq({tag, " done_seen"}, int'(bus.DONE === 1'b1), 1);
        check_eq({tag, " latency_ok"}, int'(lat <= np * 258), 1);
        obs1x = int'(bus.C1X); obs1y = int'(bus.C1Y);
        obs2x = int'(bus.C2X); obs2y = int'(bus.C2Y);
        check_eq({tag, " c1x"}, obs1x, e1x);
        check_eq({tag, " c1y"}, obs1y, e1y);
        check_eq({tag, " c2x"}, obs2x, e2x);
        check_eq({tag, " c2y"}, obs2y, e2y);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, " done_one_cycle"}, int'(bus.DONE), 0);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        bus.X = '0;
        bus.Y = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("reset done", int'(bus.DONE), 0);
        check_eq("reset c1x", int'(bus.C1X), 0);
        check_eq("reset c1y", int'(bus.C1Y), 0);
        check_eq("reset c2x", int'(bus.C2X), 0);
        check_eq("reset c2y", int'(bus.C2Y), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin px[i] = 5; py[i] = 5; end
        run_set("all55", 516);
        check_eq("all55 fixed c1x", obs1x, 5);
        check_eq("all55 fixed c1y", obs1y, 1);
        check_eq("all55 fixed c2x", obs2x, 0);
        check_eq("all55 fixed c2y", obs2y, 0);

        for (int i = 0; i < 40; i++) begin
            px[i] = (i < 20) ? 2 : 12;
            py[i] = (i < 20) ? 2 : 12;
        end
        run_set("split", 1600);
        check_eq("split fixed c1x", obs1x, 0);
        check_eq("split fixed c1y", obs1y, 0);
        check_eq("split fixed c2x", obs2x, 12);
        check_eq("split fixed c2y", obs2y, 8);

        for (int i = 0; i < 40; i++) begin
            px[i] = (i % 2 == 0) ? 4 : 0;
            py[i] = (i % 2 == 0) ? 0 : 4;
        end
        run_set("edge16", 1600);
        check_eq("edge16 fixed c1x", obs1x, 0);
        check_eq("edge16 fixed c1y", obs1y, 0);

        for (int i = 0; i < 40; i++) begin px[i] = 3; py[i] = 3; end
        run_set("dist18", 1600);
        check_eq("dist18 fixed c1x", obs1x, 1);
        check_eq("dist18 fixed c1y", obs1y, 0);

        for (int k = 0; k < 8; k++) begin
            gen_random(k % 3 != 0);
            run_set($sformatf("rand%0d", k), 1600);
        end

        gen_random(1'b1);
        feed_points(seen);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.DONE) seen = 1;
        end
        rst_n = 1'b0;
        #1;
        check_eq("midreset done", int'(bus.DONE), 0);
        check_eq("midreset c1x", int'(bus.C1X), 0);
        check_eq("midreset c2y", int'(bus.C2Y), 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.DONE) seen = 1;
        end
        check_eq("midreset no_done", int'(seen), 0);
        rst_n = 1'b1;
        gen_random(1'b1);
        run_set("after_reset", 1600);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/laser.md
# laser

Two-circle coverage optimizer. Receives a stream of 40 target points on a 16×16 grid, then searches for two circle centres of radius 4 that together cover as many points as possible. Reports both centres with a one-cycle DONE pulse, then immediately accepts the next 40-point set. It is a standalone compute block driven by a point-streaming host.

## Interface
- No parameters.
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-low reset.
- X  in  4  x coordinate of the current point, 0..15.
- Y  in  4  y coordinate of the current point, 0..15.
- C1X, C1Y  out  4 each  centre of circle 1.
- C2X, C2Y  out  4 each  centre of circle 2.
- DONE  out  1  one-cycle pulse; centres are valid while DONE=1.

## Operation
- Coverage rule: a point P is covered by centre C iff (Cx−Px)²+(Cy−Py)² ≤ 16, computed in signed arithmetic. Equivalent test: |dx|≤4, |dy|≤4 and dx²+dy²≤16.
- All 40 stored entries count separately, duplicates included.
- Union count is the number of entries covered by C1 or C2, range 0..40 (6 bits).
- States: READ, SEARCH, FINISH.
- READ:
  - Point counter runs 0..39.
  - Each rising edge stores (X,Y) at the counter index and increments the counter.
  - After index 39 is stored, go to SEARCH. Inputs are then ignored, and may be X.
- SEARCH is a sequence of passes:
  - Each pass scans all 256 candidate positions, one per cycle.
  - Scan order: cy outer 0..15, cx inner 0..15, so (0,0),(1,0)…(15,0),(0,1)…
  - The count for each candidate is evaluated combinationally over all 40 points in parallel.
- Pass 1 optimizes C1 with C2 disabled (coverage by C1 alone).
- Pass 2 optimizes C2 with C1 fixed. Pass 3 optimizes C1 with C2 fixed. Passes then continue alternating.
- Pass bookkeeping:
  - Each pass starts with best = current union count and keeps the current centre.
  - A candidate replaces the moving centre only if its union count is strictly greater than best. Ties keep the earlier or current centre.
- Start of each point set: C1 and C2 registers are cleared to (0,0), and the best count is cleared to 0.
- Termination: after any pass from pass 2 onward that yields no strict improvement, or after pass 6, go to FINISH.
- FINISH:
  - DONE=1 for exactly one cycle.
  - Next edge: DONE=0, counter=0, state=READ.
  - The first point of the next set is captured on the edge after the edge where DONE was sampled high.
- C1X..C2Y are driven directly from the centre registers. They are valid only while DONE=1 and may change during SEARCH.

## Timing
- Reset (RST=0, asynchronous): state READ, counter 0, DONE=0, and all centre outputs 0.
- A reset asserted mid-READ or mid-SEARCH aborts the operation with no DONE.
- First capture happens on the first rising edge with RST=1.
- DONE stays 0 throughout READ.
- Latency from capture of point 39 to DONE high is at most 6×(256+2) cycles, i.e. ≤1548 cycles.
- Per-pass overhead is at most 2 cycles.
- Whole block must stay well under 50000 cycles per point set.
- No input handshake: exactly one point per clock during READ. The host must present point 0 on the edge following DONE.

## Test plan
- Reset:
  - Hold RST=0 for 2 cycles → DONE=0 and C1=C2=(0,0).
  - Release RST → point 0 is captured on the next edge.
- All 40 points at (5,5):
  - Expected result C1=(5,1), C2=(0,0), cover 40.
  - Pass 2 makes no improvement, so DONE arrives ≤ 2×258 cycles after the last point.
- 20 points at (2,2) and 20 at (12,12) → C1=(0,0), C2=(12,8), cover 40.
- Back-to-back sets without reset:
  - DONE is 1 for exactly one cycle, then 0 on the next cycle.
  - The second set is captured in full and reports its own correct result.
- Boundary distance: points at (4,0) and (0,4) with centre candidate (0,0) → both counted covered (distance² = 16).
  - A point at (3,3) from centre (0,0) → not covered (distance² = 18).
- Reset pulse during SEARCH → no DONE; a fresh 40-point stream then produces the correct result.
